// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants and state type for the decode-stage branch sequencer.
package branch_resolve_ctrl_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [31:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SLOT = 2'd2
  } br_state_e;

  // Saturating increment so a long operand wait never wraps back below the limit.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// ID-stage <-> branch sequencer signal bundle. Optional stats outputs exist
// only when BRANCH_STATS_EN is defined.
interface branch_resolve_ctrl_if;
  logic        id_valid;
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [31:0] a;
  logic [31:0] b;
  logic        a_rdy;
  logic        b_rdy;
  logic [31:0] target;
  logic        stall_i;
  logic        flush_i;
  logic        stall_o;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_we;
  logic        in_delay_slot;
  logic        wait_err;
  logic        ds_branch_err;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;
  logic [31:0] stall_cnt;
`endif

  modport master (
    output id_valid, op, rt, a, b, a_rdy, b_rdy, target, stall_i, flush_i,
    input  stall_o, redirect_valid, redirect_pc, link_we, in_delay_slot,
           wait_err, ds_branch_err
`ifdef BRANCH_STATS_EN
    , input br_cnt, taken_cnt, stall_cnt
`endif
  );

  modport slave (
    input  id_valid, op, rt, a, b, a_rdy, b_rdy, target, stall_i, flush_i,
    output stall_o, redirect_valid, redirect_pc, link_we, in_delay_slot,
           wait_err, ds_branch_err
`ifdef BRANCH_STATS_EN
    , output br_cnt, taken_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Combinational branch decode and condition evaluation for the ID instruction.
module branch_cond_eval
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_branch,
  output logic        needs_b,
  output logic        is_link,
  output logic        cond
);

  logic a_zero;
  logic a_neg;

  assign a_zero = (a == ZERO_WORD);
  assign a_neg  = a[31];

  always_comb begin
    is_branch = 1'b0;
    needs_b   = 1'b0;
    is_link   = 1'b0;
    cond      = 1'b0;
    case (op)
      OP_BEQ: begin
        is_branch = 1'b1;
        needs_b   = 1'b1;
        cond      = (a == b);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        needs_b   = 1'b1;
        cond      = (a != b);
      end
      OP_BGTZ: begin
        is_branch = 1'b1;
        cond      = !a_neg && !a_zero;
      end
      OP_BLEZ: begin
        is_branch = 1'b1;
        cond      = a_neg || a_zero;
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ: begin
            is_branch = 1'b1;
            cond      = a_neg;
          end
          RT_BGEZ: begin
            is_branch = 1'b1;
            cond      = !a_neg;
          end
          RT_BLTZAL: begin
            is_branch = 1'b1;
            is_link   = 1'b1;
            cond      = a_neg;
          end
          RT_BGEZAL: begin
            is_branch = 1'b1;
            is_link   = 1'b1;
            cond      = !a_neg;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch sequencer: operand wait, resolve, delay-slot tracking.
// Define BRANCH_STATS_EN to add the br_cnt/taken_cnt/stall_cnt counters.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 resetn,
  branch_resolve_ctrl_if.slave bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_MAX);

  br_state_e   state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        link_we_q, link_we_d;
  logic        wait_err_q, wait_err_d;
  logic        ds_branch_err_q, ds_branch_err_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic is_branch, needs_b, is_link, cond;
  logic br_present, ops_rdy, resolve, stall_c;

  branch_cond_eval u_cond (
    .op        (bus.op),
    .rt        (bus.rt),
    .a         (bus.a),
    .b         (bus.b),
    .is_branch (is_branch),
    .needs_b   (needs_b),
    .is_link   (is_link),
    .cond      (cond)
  );

  assign br_present = bus.id_valid && is_branch;
  assign ops_rdy    = bus.a_rdy && (bus.b_rdy || !needs_b);

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    link_we_d        = 1'b0;
    ds_branch_err_d  = 1'b0;
    wait_err_d       = wait_err_q;
    wait_cnt_d       = wait_cnt_q;
    stall_c          = 1'b0;
    resolve          = 1'b0;

    if (bus.flush_i) begin
      state_d          = ST_IDLE;
      redirect_valid_d = 1'b0;
      wait_cnt_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (br_present) begin
            if (!ops_rdy) begin
              stall_c    = 1'b1;
              state_d    = ST_WAIT;
              wait_cnt_d = '0;
            end else if (!bus.stall_i) begin
              resolve = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // The resolving cycle releases IF/ID so the delay slot can enter.
          if (br_present && ops_rdy && !bus.stall_i) begin
            resolve = 1'b1;
          end else begin
            stall_c = 1'b1;
            if (!bus.stall_i) begin
              wait_cnt_d = sat_inc4(wait_cnt_q);
              if (wait_cnt_d >= WAIT_LIMIT) wait_err_d = 1'b1;
            end
          end
        end
        ST_SLOT: begin
          if (bus.id_valid && !bus.stall_i) begin
            state_d          = ST_IDLE;
            redirect_valid_d = 1'b0;
            ds_branch_err_d  = is_branch;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (resolve) begin
        state_d          = ST_SLOT;
        redirect_valid_d = cond;
        redirect_pc_d    = bus.target;
        link_we_d        = is_link;
        wait_cnt_d       = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ST_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= ZERO_WORD;
      link_we_q        <= 1'b0;
      wait_err_q       <= 1'b0;
      ds_branch_err_q  <= 1'b0;
      wait_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      link_we_q        <= link_we_d;
      wait_err_q       <= wait_err_d;
      ds_branch_err_q  <= ds_branch_err_d;
      wait_cnt_q       <= wait_cnt_d;
    end
  end

  assign bus.stall_o        = stall_c;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.link_we        = link_we_q;
  assign bus.in_delay_slot  = (state_q == ST_SLOT);
  assign bus.wait_err       = wait_err_q;
  assign bus.ds_branch_err  = ds_branch_err_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    br_cnt_d    = br_cnt_q + {31'd0, resolve};
    taken_cnt_d = taken_cnt_q + {31'd0, resolve && cond};
    stall_cnt_d = stall_cnt_q + {31'd0, stall_c};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl (stats checks when BRANCH_STATS_EN is defined).
module tb_branch_resolve_ctrl;

  localparam int unsigned TB_WAIT_MAX = 3;

  logic        clk;
  logic        resetn;
  int unsigned n_tests;
  int unsigned n_fail;

  branch_resolve_ctrl_if bus ();

  branch_resolve_ctrl #(.WAIT_MAX(TB_WAIT_MAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Branch kinds: 0 BEQ, 1 BNE, 2 BGTZ, 3 BLEZ, 4 BLTZ, 5 BGEZ, 6 BLTZAL, 7 BGEZAL
  function automatic logic [5:0] kop(input int unsigned k);
    case (k)
      0: return 6'h04;
      1: return 6'h05;
      2: return 6'h07;
      3: return 6'h06;
      default: return 6'h01;
    endcase
  endfunction

  function automatic logic [4:0] krt(input int unsigned k);
    case (k)
      4: return 5'h00;
      5: return 5'h01;
      6: return 5'h10;
      7: return 5'h11;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic bit ref_taken(input int unsigned k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      0: return a == b;
      1: return a != b;
      2: return $signed(a) > 0;
      3: return $signed(a) <= 0;
      4, 6: return $signed(a) < 0;
      default: return $signed(a) >= 0;
    endcase
  endfunction

  task automatic drive_idle();
    bus.id_valid = 1'b0; bus.op = 6'h00; bus.rt = '0; bus.a = '0; bus.b = '0;
    bus.a_rdy = 1'b0; bus.b_rdy = 1'b0; bus.target = '0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
  endtask

  task automatic drive_br(input int unsigned k, input logic [31:0] a, input logic [31:0] b,
                          input logic ar, input logic br, input logic [31:0] tgt);
    bus.id_valid = 1'b1; bus.op = kop(k); bus.rt = krt(k); bus.a = a; bus.b = b;
    bus.a_rdy = ar; bus.b_rdy = br; bus.target = tgt;
  endtask

  task automatic drive_nonbranch();
    bus.id_valid = 1'b1; bus.op = 6'h23; bus.rt = '0; bus.a_rdy = 1'b0; bus.b_rdy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", bus.stall_o); end
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rv: got %b exp 0", bus.redirect_valid); end
    n_tests++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", bus.redirect_pc); end
    n_tests++; if (bus.link_we !== 1'b0) begin n_fail++; $display("FAIL rst_link: got %b exp 0", bus.link_we); end
    n_tests++; if (bus.in_delay_slot !== 1'b0) begin n_fail++; $display("FAIL rst_ds: got %b exp 0", bus.in_delay_slot); end
    n_tests++; if (bus.wait_err !== 1'b0) begin n_fail++; $display("FAIL rst_werr: got %b exp 0", bus.wait_err); end
    n_tests++; if (bus.ds_branch_err !== 1'b0) begin n_fail++; $display("FAIL rst_dserr: got %b exp 0", bus.ds_branch_err); end
    next_cycle();
    resetn = 1'b1;
    next_cycle();
  endtask

  task automatic test_beq_taken();
    drive_br(0, 32'h1234, 32'h1234, 1'b1, 1'b1, 32'h400);
    @(negedge clk);
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL beq_stall: got %b exp 0", bus.stall_o); end
    next_cycle();
    drive_nonbranch();
    @(negedge clk);
    n_tests++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_rv: got %b exp 1", bus.redirect_valid); end
    n_tests++; if (bus.redirect_pc !== 32'h400) begin n_fail++; $display("FAIL beq_pc: got %h exp 400", bus.redirect_pc); end
    n_tests++; if (bus.in_delay_slot !== 1'b1) begin n_fail++; $display("FAIL beq_ds: got %b exp 1", bus.in_delay_slot); end
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL beq_slot_stall: got %b exp 0", bus.stall_o); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_rv_clr: got %b exp 0", bus.redirect_valid); end
    n_tests++; if (bus.in_delay_slot !== 1'b0) begin n_fail++; $display("FAIL beq_ds_clr: got %b exp 0", bus.in_delay_slot); end
    next_cycle();
  endtask

  task automatic test_bne_wait();
    int unsigned stalls;
    stalls = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      drive_br(1, 32'd5, 32'd5, 1'b1, 1'b0, 32'h800);
      @(negedge clk);
      if (bus.stall_o === 1'b1) stalls++;
      next_cycle();
    end
    drive_br(1, 32'd5, 32'd5, 1'b1, 1'b1, 32'h800);
    @(negedge clk);
    if (bus.stall_o === 1'b1) stalls++;
    n_tests++; if (stalls !== 2) begin n_fail++; $display("FAIL bne_stall_cycles: got %0d exp 2", stalls); end
    next_cycle();
    drive_nonbranch();
    @(negedge clk);
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bne_rv: got %b exp 0", bus.redirect_valid); end
    n_tests++; if (bus.in_delay_slot !== 1'b1) begin n_fail++; $display("FAIL bne_ds: got %b exp 1", bus.in_delay_slot); end
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  task automatic test_link();
    drive_br(7, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h1000);
    next_cycle();
    drive_nonbranch();
    @(negedge clk);
    n_tests++; if (bus.link_we !== 1'b1) begin n_fail++; $display("FAIL bgezal_link: got %b exp 1", bus.link_we); end
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bgezal_rv: got %b exp 0", bus.redirect_valid); end
    next_cycle();
    drive_br(3, 32'h0, 32'h0, 1'b1, 1'b0, 32'h2000);
    @(negedge clk);
    n_tests++; if (bus.link_we !== 1'b0) begin n_fail++; $display("FAIL bgezal_link_pulse: got %b exp 0", bus.link_we); end
    next_cycle();
    drive_nonbranch();
    @(negedge clk);
    n_tests++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL blez_rv: got %b exp 1", bus.redirect_valid); end
    n_tests++; if (bus.link_we !== 1'b0) begin n_fail++; $display("FAIL blez_link: got %b exp 0", bus.link_we); end
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  task automatic test_random_branches();
    int unsigned k, dly, sel, r;
    logic [31:0] a, b, tgt;
    bit exp_taken, two, lnk;
    for (int unsigned it = 0; it < 40; it++) begin
      k = $urandom_range(0, 7);
      dly = $urandom_range(0, 3);
      sel = $urandom_range(0, 3);
      a = $urandom; b = $urandom; tgt = $urandom & 32'hFFFF_FFFC;
      case (sel)
        0: b = a;
        1: a = '0;
        2: a[31] = 1'b1;
        default: ;
      endcase
      exp_taken = ref_taken(k, a, b);
      two = (k < 2);
      lnk = (k >= 6);
      drive_nonbranch();
      @(negedge clk);
      n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rnd_nonbr_stall[%0d]: got %b exp 0", it, bus.stall_o); end
      next_cycle();
      for (int unsigned d = 0; d < dly; d++) begin
        r = $urandom_range(0, 2);
        if (two) drive_br(k, a, b, r == 1, r == 2, tgt);
        else     drive_br(k, a, b, 1'b0, 1'($urandom), tgt);
        @(negedge clk);
        n_tests++; if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL rnd_wait_stall[%0d]: got %b exp 1", it, bus.stall_o); end
        next_cycle();
      end
      drive_br(k, a, b, 1'b1, two ? 1'b1 : 1'($urandom), tgt);
      @(negedge clk);
      n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rnd_rdy_stall[%0d]: got %b exp 0", it, bus.stall_o); end
      next_cycle();
      drive_nonbranch();
      @(negedge clk);
      n_tests++; if (bus.redirect_valid !== exp_taken) begin n_fail++; $display("FAIL rnd_rv[%0d] kind %0d a %h b %h: got %b exp %b", it, k, a, b, bus.redirect_valid, exp_taken); end
      n_tests++; if (bus.redirect_pc !== tgt) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h exp %h", it, bus.redirect_pc, tgt); end
      n_tests++; if (bus.in_delay_slot !== 1'b1) begin n_fail++; $display("FAIL rnd_ds[%0d]: got %b exp 1", it, bus.in_delay_slot); end
      n_tests++; if (bus.link_we !== lnk) begin n_fail++; $display("FAIL rnd_link[%0d]: got %b exp %b", it, bus.link_we, lnk); end
      next_cycle();
      drive_idle();
      @(negedge clk);
      n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_rv_clr[%0d]: got %b exp 0", it, bus.redirect_valid); end
      n_tests++; if (bus.in_delay_slot !== 1'b0) begin n_fail++; $display("FAIL rnd_ds_clr[%0d]: got %b exp 0", it, bus.in_delay_slot); end
      n_tests++; if (bus.wait_err !== 1'b0) begin n_fail++; $display("FAIL rnd_werr[%0d]: got %b exp 0", it, bus.wait_err); end
      next_cycle();
    end
  endtask

  task automatic test_slot_stall();
    drive_br(0, 32'h77, 32'h77, 1'b1, 1'b1, 32'h3000);
    next_cycle();
    for (int unsigned i = 0; i < 4; i++) begin
      drive_nonbranch();
      bus.stall_i = 1'b1;
      @(negedge clk);
      n_tests++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL slotstall_rv[%0d]: got %b exp 1", i, bus.redirect_valid); end
      n_tests++; if (bus.in_delay_slot !== 1'b1) begin n_fail++; $display("FAIL slotstall_ds[%0d]: got %b exp 1", i, bus.in_delay_slot); end
      n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL slotstall_stall[%0d]: got %b exp 0", i, bus.stall_o); end
      next_cycle();
    end
    bus.stall_i = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.redirect_pc !== 32'h3000) begin n_fail++; $display("FAIL slotstall_pc: got %h exp 3000", bus.redirect_pc); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL slotstall_rv_clr: got %b exp 0", bus.redirect_valid); end
    next_cycle();
  endtask

  task automatic test_ds_branch();
    drive_br(0, 32'h9, 32'h9, 1'b1, 1'b1, 32'h4000);
    next_cycle();
    drive_br(1, 32'h1, 32'h2, 1'b1, 1'b1, 32'h5000);
    @(negedge clk);
    n_tests++; if (bus.ds_branch_err !== 1'b0) begin n_fail++; $display("FAIL dsbr_early: got %b exp 0", bus.ds_branch_err); end
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.ds_branch_err !== 1'b1) begin n_fail++; $display("FAIL dsbr_pulse: got %b exp 1", bus.ds_branch_err); end
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL dsbr_rv: got %b exp 0", bus.redirect_valid); end
    n_tests++; if (bus.in_delay_slot !== 1'b0) begin n_fail++; $display("FAIL dsbr_ds: got %b exp 0", bus.in_delay_slot); end
    n_tests++; if (bus.redirect_pc !== 32'h4000) begin n_fail++; $display("FAIL dsbr_pc: got %h exp 4000", bus.redirect_pc); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.ds_branch_err !== 1'b0) begin n_fail++; $display("FAIL dsbr_clr: got %b exp 0", bus.ds_branch_err); end
    next_cycle();
  endtask

  task automatic test_flush_resolve();
    drive_br(7, 32'h5, 32'h0, 1'b1, 1'b0, 32'h6000);
    bus.flush_i = 1'b1;
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL flushres_rv: got %b exp 0", bus.redirect_valid); end
    n_tests++; if (bus.link_we !== 1'b0) begin n_fail++; $display("FAIL flushres_link: got %b exp 0", bus.link_we); end
    n_tests++; if (bus.in_delay_slot !== 1'b0) begin n_fail++; $display("FAIL flushres_ds: got %b exp 0", bus.in_delay_slot); end
    next_cycle();
  endtask

  task automatic test_wait_err();
    bit exp_err;
    for (int i = 0; i < 7; i++) begin
      drive_br(4, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 32'h7000);
      @(negedge clk);
      exp_err = (i - 1) >= int'(TB_WAIT_MAX);
      n_tests++; if (bus.wait_err !== exp_err) begin n_fail++; $display("FAIL werr[%0d]: got %b exp %b", i, bus.wait_err, exp_err); end
      n_tests++; if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL werr_stall[%0d]: got %b exp 1", i, bus.stall_o); end
      next_cycle();
    end
    bus.flush_i = 1'b1;
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL werr_flush_stall: got %b exp 0", bus.stall_o); end
    n_tests++; if (bus.in_delay_slot !== 1'b0) begin n_fail++; $display("FAIL werr_flush_ds: got %b exp 0", bus.in_delay_slot); end
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL werr_flush_rv: got %b exp 0", bus.redirect_valid); end
    n_tests++; if (bus.wait_err !== 1'b1) begin n_fail++; $display("FAIL werr_sticky: got %b exp 1", bus.wait_err); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive_br(5, 32'h1, 32'h0, 1'b0, 1'b0, 32'h8000);
    next_cycle();
    next_cycle();
    @(negedge clk); #2;
    resetn = 1'b0;
    drive_idle();
    #1;
    n_tests++; if (bus.wait_err !== 1'b0) begin n_fail++; $display("FAIL rstwait_werr: got %b exp 0", bus.wait_err); end
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rstwait_stall: got %b exp 0", bus.stall_o); end
    next_cycle();
    resetn = 1'b1;
    drive_br(7, 32'h1, 32'h0, 1'b1, 1'b0, 32'h9000);
    next_cycle();
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.link_we !== 1'b1) begin n_fail++; $display("FAIL rstslot_pre_link: got %b exp 1", bus.link_we); end
    #2;
    resetn = 1'b0;
    #1;
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rstslot_rv: got %b exp 0", bus.redirect_valid); end
    n_tests++; if (bus.link_we !== 1'b0) begin n_fail++; $display("FAIL rstslot_link: got %b exp 0", bus.link_we); end
    n_tests++; if (bus.in_delay_slot !== 1'b0) begin n_fail++; $display("FAIL rstslot_ds: got %b exp 0", bus.in_delay_slot); end
    n_tests++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rstslot_pc: got %h exp 0", bus.redirect_pc); end
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rstslot_after_rv: got %b exp 0", bus.redirect_valid); end
    next_cycle();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    int unsigned exp_br, exp_taken, exp_stall;
    int unsigned kinds [3];
    logic [31:0] av [3];
    logic [31:0] bv [3];
    int unsigned dl [3];
    kinds = '{0, 1, 4}; av = '{32'h11, 32'h1, 32'h1}; bv = '{32'h11, 32'h2, 32'h0}; dl = '{0, 2, 0};
    resetn = 1'b0; drive_idle(); next_cycle(); resetn = 1'b1; next_cycle();
    exp_br = 0; exp_taken = 0; exp_stall = 0;
    for (int unsigned n = 0; n < 3; n++) begin
      for (int unsigned d = 0; d < dl[n]; d++) begin
        drive_br(kinds[n], av[n], bv[n], 1'b1, 1'b0, 32'hA000);
        exp_stall++;
        next_cycle();
      end
      drive_br(kinds[n], av[n], bv[n], 1'b1, 1'b1, 32'hA000);
      exp_br++;
      if (ref_taken(kinds[n], av[n], bv[n])) exp_taken++;
      next_cycle();
      drive_nonbranch();
      next_cycle();
      drive_idle();
      next_cycle();
    end
    @(negedge clk);
    n_tests++; if (bus.br_cnt !== exp_br) begin n_fail++; $display("FAIL stats_br: got %0d exp %0d", bus.br_cnt, exp_br); end
    n_tests++; if (bus.taken_cnt !== exp_taken) begin n_fail++; $display("FAIL stats_taken: got %0d exp %0d", bus.taken_cnt, exp_taken); end
    n_tests++; if (bus.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL stats_stall: got %0d exp %0d", bus.stall_cnt, exp_stall); end
    #2;
    resetn = 1'b0;
    #1;
    n_tests++; if (bus.br_cnt !== 32'd0) begin n_fail++; $display("FAIL stats_rst_br: got %0d exp 0", bus.br_cnt); end
    n_tests++; if (bus.taken_cnt !== 32'd0) begin n_fail++; $display("FAIL stats_rst_taken: got %0d exp 0", bus.taken_cnt); end
    n_tests++; if (bus.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL stats_rst_stall: got %0d exp 0", bus.stall_cnt); end
    next_cycle();
    resetn = 1'b1;
    next_cycle();
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    drive_idle();
    next_cycle();
    test_reset();
    test_beq_taken();
    test_bne_wait();
    test_link();
    test_random_branches();
    test_slot_stall();
    test_ds_branch();
    test_flush_resolve();
    test_wait_err();
    test_reset_mid();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Decode-stage branch sequencer for the five-stage MIPS core. It detects conditional branches in ID and holds IF/ID until the forwarding/hazard unit reports the compare operands ready. It then resolves the branch condition and issues a registered PC redirect that takes effect after the delay slot. It also tracks delay-slot occupancy for precise exceptions and raises an error when operands never become ready.

## Interface
- WAIT_MAX, default 15: maximum operand-wait cycles before `wait_err`; range 1..15.
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- id_valid  in  1  valid instruction in ID
- op  in  6  opcode of ID instruction
- rt  in  5  rt field of ID instruction
- a, b  in  32 each  forwarded rs/rt values
- a_rdy, b_rdy  in  1 each  forwarding unit: a/b is final this cycle
- target  in  32  branch target (PC+4+offset<<2), computed in ID
- stall_i  in  1  downstream pipeline stall
- flush_i  in  1  exception/eret flush
- stall_o  out  1  freeze PC and IF/ID
- redirect_valid  out  1  fetch must take redirect_pc
- redirect_pc  out  32  registered target
- link_we  out  1  one-cycle pulse: write PC+8 to $31 (BLTZAL/BGEZAL)
- in_delay_slot  out  1  ID instruction is a delay slot
- wait_err  out  1  sticky: wait exceeded WAIT_MAX
- ds_branch_err  out  1  one-cycle pulse: branch found in a delay slot

## Operation
- Branch class:
  - Two-operand (needs a_rdy & b_rdy): BEQ, BNE.
  - One-operand (needs a_rdy only): BGTZ, BLEZ, REGIMM with rt in {BLTZ, BGEZ, BLTZAL, BGEZAL}.
- Conditions:
  - BEQ: a==b. BNE: a!=b.
  - BGTZ: !a[31] && a!=0. BLEZ: a[31] || a==0.
  - BGEZ/BGEZAL: !a[31]. BLTZ/BLTZAL: a[31].
- Resolve event: branch present, required operands ready, !stall_i, !flush_i. On resolve:
  - redirect_valid <= cond; redirect_pc <= target.
  - link_we pulses for *AL regardless of cond.
- FSM states IDLE, WAIT, SLOT:
  - IDLE: a branch with operands ready resolves and goes to SLOT. A branch with operands not ready goes to WAIT; stall_o=1 combinationally in that same cycle.
  - WAIT: stall_o=1. Resolve goes to SLOT. A 4-bit wait counter increments each WAIT cycle. When the count reaches WAIT_MAX, wait_err sets and stays set until reset; the FSM keeps waiting.
  - SLOT: in_delay_slot=1. Leaves to IDLE on id_valid & !stall_i, which is the delay slot accepted; redirect_valid clears on that exit. A branch in ID while in SLOT is not resolved; ds_branch_err pulses.
- flush_i has the highest priority in every state. Next state is IDLE; redirect_valid, link_we and the counter clear; wait_err is kept.
- stall_i in SLOT or WAIT holds state and all registered outputs.

## Timing
- Reset values: state IDLE, all outputs 0, counter 0, redirect_pc 0.
- Operands ready in cycle t: redirect_valid=1 at t+1, aligned with fetch of the instruction after the delay slot.
- Each operand-wait cycle adds exactly one cycle of stall_o. stall_o is never asserted in SLOT.
- Not-taken branch: still passes through SLOT for the delay slot; redirect_valid stays 0.
- Reset asserted mid-WAIT or mid-SLOT: immediate return to reset values, with no redirect or link pulse.
- flush_i and resolve in the same cycle: the flush wins; no redirect.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs br_cnt, taken_cnt, stall_cnt, each 32 bits, each wrapping modulo 2^32.
  - br_cnt and taken_cnt count resolve events and taken resolves.
  - stall_cnt counts cycles with stall_o=1.
  - Counters reset to 0 and are not cleared by flush_i.
- Undefined: these ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package/header holds:
  - opcode and REGIMM rt constants (BEQ, BNE, BGTZ, BLEZ, REGIMM, BLTZ, BGEZ, BLTZAL, BGEZAL);
  - the state encoding;
  - ZERO_WORD.
- One sub-module, branch_cond_eval, is purely combinational (op, rt, a, b → is_branch, needs_b, is_link, cond). The FSM, counter and registered outputs live in the top.

## Test plan
- BEQ, a=b=0x1234, both ready, target 0x400 → next cycle redirect_valid=1, redirect_pc=0x400, in_delay_slot=1, no stall.
- BNE, b_rdy low for 2 cycles → stall_o=1 exactly 2 cycles, then resolve; a=5, b=5 → redirect_valid stays 0, SLOT entered.
- BGEZAL, a=0xFFFFFFFF → link_we pulses once, redirect_valid=0. BLEZ, a=0 → taken.
- WAIT with a_rdy low, WAIT_MAX=3 → wait_err=1 after the 3rd wait cycle and stays 1. flush_i → IDLE, stall_o=0, wait_err still 1.
- Branch in SLOT → ds_branch_err one-cycle pulse, no new redirect. stall_i high in SLOT for 4 cycles → redirect_valid held.
- With BRANCH_STATS_EN: 3 branches (2 taken, one waiting 2 cycles) → br_cnt=3, taken_cnt=2, stall_cnt=2. resetn low mid-run → all counters 0.
